// File: rtl/if_fetch_ctrl_pkg.sv
// Shared widths, constants and state encoding for the instruction-fetch sequencer.
package if_fetch_ctrl_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(0);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_HELD  = 2'd2
  } fetch_state_e;

  // PC increment; wraps silently at the top of the address space.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/if_hold_reg.sv
// Instruction capture register with load enable and synchronous reset to NOP,
// used as the skid buffer that keeps instr_out stable across a stall.
module if_hold_reg
  import if_fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [INSTR_W-1:0] d,
  output logic [INSTR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= NOP;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the synchronous imem and
// presents (pc, instr, valid) to the IF/ID boundary with stall and redirect.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_plus1,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_out_q;
  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_hold_q;
  logic               hold_load;
  logic               hold_clr;

  // PC and fetch state; priority rst > branch > stall > advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      state_q  <= S_EMPTY;
    end else if (branch_taken) begin
      pc_q    <= branch_target;
      state_q <= S_EMPTY;
    end else if (stall) begin
      if (state_q == S_RUN) begin
        state_q <= S_HELD;
      end
    end else begin
      pc_out_q <= pc_q;
      pc_q     <= pc_inc(pc_q);
      state_q  <= S_RUN;
    end
  end

  // Capture the live imem word only on the first stalled cycle; a redirect
  // discards whatever was held.
  assign hold_load = !rst && !branch_taken && stall && (state_q == S_RUN);
  assign hold_clr  = rst || branch_taken;

  if_hold_reg u_hold (
    .clk  (clk),
    .rst  (hold_clr),
    .load (hold_load),
    .d    (imem_rdata),
    .q    (instr_hold_q)
  );

  always_comb begin
    instr_out = NOP;
    case (state_q)
      S_RUN:   instr_out = imem_rdata;
      S_HELD:  instr_out = instr_hold_q;
      default: instr_out = NOP;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_out_q;
  assign pc_plus1  = pc_inc(pc_out_q);
  assign valid_out = (state_q != S_EMPTY);

endmodule
